// File: rtl/spi_flash_xfer.sv
// SPI mode-0 transaction engine: a write phase of wr_len bytes, then a
// read phase of rd_len bytes, with chip select held low across both.
module spi_flash_xfer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned CS_IDLE    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  spi_sck,
  output logic                  spi_cs,
  output logic                  spi_sio_0,
  input  logic                  spi_sio_1
);

  localparam int unsigned CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, WR_LOAD, WR_SHIFT, RD_SHIFT, RD_PUSH, CS_HOLD, CS_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [LEN_WIDTH-1:0]    wr_cnt, rd_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    half_end, gap_end, last_bit;
  logic                    tx_fire, rx_fire, wr_more, rd_more;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and handshake strobes
  always_comb begin
    half_end = (div_cnt == CW'(CLK_DIV - 1));
    gap_end  = (div_cnt == CW'(CS_IDLE - 1));
    last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
    tx_ready = (state_q == WR_LOAD);
    tx_fire  = tx_ready & tx_valid;
    rx_fire  = rx_valid & rx_ready;
    wr_more  = (wr_cnt != LEN_WIDTH'(1));
    rd_more  = (rd_cnt != LEN_WIDTH'(1));
    state_d  = state_q;
    case (state_q)
      IDLE:     if (start && !busy && (wr_len != '0 || rd_len != '0)) state_d = CS_SETUP;
      CS_SETUP: if (half_end) state_d = (wr_cnt != '0) ? WR_LOAD : RD_SHIFT;
      WR_LOAD:  if (tx_fire) state_d = WR_SHIFT;
      WR_SHIFT: if (half_end && spi_sck && last_bit)
                  state_d = wr_more ? WR_LOAD : ((rd_cnt != '0) ? RD_SHIFT : CS_HOLD);
      RD_SHIFT: if (half_end && spi_sck && last_bit) state_d = RD_PUSH;
      RD_PUSH:  if (rx_fire) state_d = rd_more ? RD_SHIFT : CS_HOLD;
      CS_HOLD:  if (half_end) state_d = CS_GAP;
      CS_GAP:   if (gap_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath: dividers, shift register, byte counters and registered pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_cs    <= 1'b1;
      spi_sck   <= 1'b0;
      spi_sio_0 <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      shreg     <= '0;
    end else begin
      // busy falls together with the end of the done pulse
      if (done) begin
        done <= 1'b0;
        busy <= 1'b0;
      end
      div_cnt <= '0;
      case (state_q)
        IDLE: begin
          if (start && !busy) begin
            wr_cnt <= wr_len;
            rd_cnt <= rd_len;
            busy   <= 1'b1;
            if (wr_len == '0 && rd_len == '0) done   <= 1'b1;
            else                              spi_cs <= 1'b0;
          end
        end
        CS_SETUP, CS_HOLD: begin
          if (!half_end) div_cnt <= div_cnt + 1'b1;
          else if (state_q == CS_HOLD) spi_cs <= 1'b1;
        end
        CS_GAP: begin
          if (!gap_end) div_cnt <= div_cnt + 1'b1;
          else          done    <= 1'b1;
        end
        WR_LOAD: begin
          if (tx_fire) begin
            shreg     <= tx_data;
            spi_sio_0 <= tx_data[DATA_WIDTH-1];
            bit_cnt   <= '0;
          end
        end
        WR_SHIFT: begin
          if (!half_end) div_cnt <= div_cnt + 1'b1;
          else begin
            spi_sck <= ~spi_sck;
            // MOSI moves only on the falling edge
            if (spi_sck) begin
              if (last_bit) begin
                wr_cnt    <= wr_cnt - 1'b1;
                spi_sio_0 <= 1'b0;
                bit_cnt   <= '0;
              end else begin
                bit_cnt   <= bit_cnt + 1'b1;
                shreg     <= shreg << 1;
                spi_sio_0 <= shreg[DATA_WIDTH-2];
              end
            end
          end
        end
        RD_SHIFT: begin
          if (!half_end) div_cnt <= div_cnt + 1'b1;
          else begin
            spi_sck <= ~spi_sck;
            if (!spi_sck) shreg <= {shreg[DATA_WIDTH-2:0], spi_sio_1};
            else if (last_bit) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
        end
        RD_PUSH: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            rd_cnt   <= rd_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_xfer.sv
// Scoreboard bench for spi_flash_xfer with a mode-0 flash model.
module tb_spi_flash_xfer;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 16;
  localparam int unsigned CD = 3;
  localparam int unsigned CI = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] wr_len = '0, rd_len = '0;
  logic          busy, done, tx_ready, rx_valid, spi_sck, spi_cs, spi_sio_0;
  logic [DW-1:0] tx_data = '0, rx_data;
  logic          tx_valid = 1'b0, rx_ready = 1'b1;
  logic          miso = 1'b0;

  always #5 clk = ~clk;

  spi_flash_xfer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CLK_DIV(CD), .CS_IDLE(CI)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wr_len(wr_len), .rd_len(rd_len),
    .busy(busy), .done(done), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .spi_sck(spi_sck), .spi_cs(spi_cs), .spi_sio_0(spi_sio_0), .spi_sio_1(miso)
  );

  int unsigned n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_rx[$];
  logic [7:0]  exp_mosi[$];
  logic [7:0]  resp[4];
  logic [7:0]  txb[4];
  int unsigned cur_wr = 0;
  int unsigned rise_cnt = 0, cs_falls = 0, cs_rises = 0, n_done = 0;
  logic        prev_cs = 1'b1, prev_sck = 1'b0;
  logic [7:0]  mosi_sh = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ge(input string name, input int unsigned act, input int unsigned min);
    n_cmp++;
    if (act < min) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
    end
  endtask

  // Flash model: drives 1s during the write phase, then the response bytes MSB first
  function automatic logic miso_bit(input int unsigned rc);
    int unsigned idx;
    logic [7:0]  b;
    if (rc < 8 * cur_wr) return 1'b1;
    idx = rc - 8 * cur_wr;
    if (idx / 8 >= 4) return 1'b0;
    b = resp[idx / 8];
    return b[7 - (idx % 8)];
  endfunction

  // Flash pins: capture MOSI on rise, update MISO on fall, score write bytes
  always @(spi_cs or spi_sck) begin
    if (!spi_cs && prev_cs) begin
      rise_cnt = 0;
      cs_falls++;
      miso = miso_bit(0);
    end else if (spi_cs && !prev_cs) begin
      cs_rises++;
    end else if (!spi_cs && spi_sck && !prev_sck) begin
      mosi_sh = {mosi_sh[6:0], spi_sio_0};
      rise_cnt++;
      if (rise_cnt % 8 == 0 && rise_cnt <= 8 * cur_wr) begin
        if (exp_mosi.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mosi_extra: got 0x%0h, expected no byte", mosi_sh);
        end else check("mosi_byte", 32'(mosi_sh), 32'(exp_mosi.pop_front()));
      end
    end else if (!spi_cs && !spi_sck && prev_sck) begin
      miso = miso_bit(rise_cnt);
    end
    prev_cs  = spi_cs;
    prev_sck = spi_sck;
  end

  // Read-stream monitor
  always @(negedge clk) begin
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rx_extra: got 0x%0h, expected no byte", rx_data);
      end else check("rx_byte", 32'(rx_data), 32'(exp_rx.pop_front()));
    end
  end

  // Pin timing monitor: SCK widths, CS setup and CS idle gap
  int unsigned hi_run = 0, lo_run = 0, cs_hi_run = 0, cs_lo_run = 0;
  logic        t_sck = 1'b0, t_cs = 1'b1, gap_armed = 1'b0, first_rise = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hi_run = 0; lo_run = 0; cs_hi_run = 0; cs_lo_run = 0;
      t_sck = 1'b0; t_cs = 1'b1; gap_armed = 1'b0; first_rise = 1'b0;
    end else begin
      if (done) n_done++;
      if (spi_sck && !t_sck) begin
        check_ge("sck_low_width", lo_run, CD);
        check("sck_rise_cs_low", 32'(spi_cs), 32'd0);
        if (first_rise) begin
          check_ge("cs_to_first_rise", cs_lo_run, CD);
          first_rise = 1'b0;
        end
      end
      if (!spi_sck && t_sck) check("sck_high_width", hi_run, CD);
      if (!spi_cs && t_cs) begin
        if (gap_armed) check_ge("cs_idle_gap", cs_hi_run, CI);
        first_rise = 1'b1;
      end
      if (spi_cs && !t_cs) gap_armed = 1'b1;
      hi_run    = spi_sck ? hi_run + 1 : 0;
      lo_run    = spi_sck ? 0 : lo_run + 1;
      cs_hi_run = spi_cs ? cs_hi_run + 1 : 0;
      cs_lo_run = spi_cs ? 0 : cs_lo_run + 1;
      t_sck = spi_sck;
      t_cs  = spi_cs;
    end
  end

  task automatic do_start(input int unsigned wl, input int unsigned rl);
    @(posedge clk); #1;
    wr_len = LW'(wl); rd_len = LW'(rl); cur_wr = wl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int unsigned w;
    w = 0;
    while (!done && w < 5000) begin @(negedge clk); w++; end
    check(name, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic feed_tx(input int unsigned n, input int unsigned stall_idx, input int unsigned stall_len);
    int unsigned w, bad;
    for (int unsigned i = 0; i < n; i++) begin
      if (i == stall_idx) begin
        w = 0;
        while (!tx_ready && w < 2000) begin @(negedge clk); w++; end
        bad = 0;
        for (int unsigned k = 0; k < stall_len; k++) begin
          @(negedge clk);
          if (spi_sck || spi_cs) bad++;
        end
        check("underflow_bus_idle", bad, 0);
        @(posedge clk); #1;
      end
      tx_data = txb[i]; tx_valid = 1'b1;
      w = 0;
      do begin @(negedge clk); w++; end while (!tx_ready && w < 2000);
      check("tx_accept", 32'(tx_ready), 32'd1);
      @(posedge clk); #1;
      tx_valid = 1'b0; tx_data = '0;
    end
  endtask

  task automatic jedec(input bit poke_start);
    int unsigned d0;
    resp = '{8'hEF, 8'h40, 8'h18, 8'h00};
    txb  = '{8'h9F, 8'h00, 8'h00, 8'h00};
    exp_mosi.push_back(8'h9F);
    exp_rx.push_back(8'hEF); exp_rx.push_back(8'h40); exp_rx.push_back(8'h18);
    cs_falls = 0; cs_rises = 0; d0 = n_done;
    do_start(1, 3);
    check("jedec_busy", 32'(busy), 32'd1);
    fork
      feed_tx(1, 99, 0);
      if (poke_start) begin
        repeat (10) @(posedge clk);
        #1; wr_len = 16'd5; rd_len = 16'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
      end
      wait_done("jedec_done");
    join
    repeat (20) @(posedge clk);
    #1;
    check("jedec_rises", rise_cnt, 32);
    check("jedec_cs_falls", cs_falls, 1);
    check("jedec_cs_rises", cs_rises, 1);
    check("jedec_done_count", n_done - d0, 1);
    check("jedec_rx_left", exp_rx.size(), 0);
    check("jedec_mosi_left", exp_mosi.size(), 0);
    check("jedec_idle_busy", 32'(busy), 32'd0);
    check("jedec_idle_cs", 32'(spi_cs), 32'd1);
  endtask

  task automatic backpressure();
    int unsigned w, bad;
    resp = '{8'h12, 8'h34, 8'h00, 8'h00};
    txb  = '{8'h03, 8'h00, 8'h00, 8'h00};
    exp_mosi.push_back(8'h03);
    exp_rx.push_back(8'h12); exp_rx.push_back(8'h34);
    rx_ready = 1'b0;
    do_start(1, 2);
    fork
      feed_tx(1, 99, 0);
      begin
        w = 0;
        while (!rx_valid && w < 2000) begin @(negedge clk); w++; end
        check("bp_valid_seen", 32'(rx_valid), 32'd1);
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (!rx_valid || rx_data != 8'h12 || spi_sck) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_no_sck", rise_cnt, 16);
        @(posedge clk); #1;
        rx_ready = 1'b1;
      end
      wait_done("bp_done");
    join
    check("bp_rises", rise_cnt, 24);
    check("bp_rx_left", exp_rx.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int unsigned d0, w;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_sck", 32'(spi_sck), 32'd0);
    check("rst_mosi", 32'(spi_sio_0), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    jedec(1'b1);

    // zero length
    cs_falls = 0; d0 = n_done;
    do_start(0, 0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("zero_done_end", 32'(done), 32'd0);
    check("zero_busy_end", 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("zero_cs_falls", cs_falls, 0);
    check("zero_done_count", n_done - d0, 1);

    // underflow after byte 2
    txb = '{8'hA5, 8'h3C, 8'hC3, 8'h5A};
    for (int i = 0; i < 4; i++) exp_mosi.push_back(txb[i]);
    cs_rises = 0;
    do_start(4, 0);
    fork
      feed_tx(4, 2, 50);
      wait_done("uf_done");
    join
    check("uf_rises", rise_cnt, 32);
    check("uf_mosi_left", exp_mosi.size(), 0);
    check("uf_cs_rises", cs_rises, 1);

    backpressure();

    // reset during bit 4 of a write byte
    resp = '{8'hEF, 8'h40, 8'h18, 8'h00};
    txb  = '{8'h9F, 8'h00, 8'h00, 8'h00};
    exp_mosi.push_back(8'h9F);
    do_start(1, 3);
    feed_tx(1, 99, 0);
    w = 0;
    while (rise_cnt < 4 && w < 2000) begin @(negedge clk); w++; end
    check("rst_mid_bit4", rise_cnt, 4);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_cs", 32'(spi_cs), 32'd1);
    check("rst_mid_sck", 32'(spi_sck), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_mosi", 32'(spi_sio_0), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_mosi.delete();
    exp_rx.delete();
    repeat (2) @(posedge clk);

    jedec(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
